// File: rtl/char_render_pkg.sv
// char_render_pkg
// Shared geometry, memory address widths and fetch FSM state encoding for the
// character-tile renderer.
package char_render_pkg;

  localparam int TILE_W   = 8;
  localparam int TILE_H   = 8;
  localparam int COLS     = 40;
  localparam int ROWS     = 30;
  localparam int CHRAM_AW = 13;
  localparam int CHROM_AW = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RAM_REQ  = 3'd1,
    ST_RAM_WAIT = 3'd2,
    ST_ROM_REQ  = 3'd3,
    ST_ROM_WAIT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/char_render_if.sv
// char_render_if
// Read ports of the character RAM (tile codes) and character ROM (glyph rows).
// Both memories return data one clock after the address is presented.
//   master : renderer side (drives addresses, receives data)
//   slave  : memory side
interface char_render_if;
  import char_render_pkg::*;

  logic [CHRAM_AW-1:0] chram_addr;
  logic [7:0]          chram_q;
  logic [CHROM_AW-1:0] chrom_addr;
  logic [7:0]          chrom_q;

  modport master (output chram_addr, output chrom_addr,
                  input  chram_q,    input  chrom_q);
  modport slave  (input  chram_addr, input  chrom_addr,
                  output chram_q,    output chrom_q);
endinterface

// File: rtl/char_render_fetch_fsm.sv
// char_fetch_fsm
// Fetches one glyph row: tile code from char RAM, then the glyph row from
// char ROM, and parks it in next_buf for the pixel shifter.
//   trigger    : start a fetch (ignored while busy)
//   col, line  : tile column and pixel line to fetch
//   chram_*    : char RAM read port
//   chrom_*    : char ROM read port
//   next_buf   : fetched glyph row
//   busy       : a fetch is in progress
//
// state    | meaning
// IDLE     | waiting for a trigger
// RAM_REQ  | tile address presented to char RAM
// RAM_WAIT | tile code on chram_q, form glyph address
// ROM_REQ  | glyph address presented to char ROM
// ROM_WAIT | glyph row on chrom_q, capture into next_buf
module char_fetch_fsm
  import char_render_pkg::*;
(
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                trigger,
  input  logic [5:0]          col,
  input  logic [8:0]          line,
  output logic [CHRAM_AW-1:0] chram_addr,
  input  logic [7:0]          chram_q,
  output logic [CHROM_AW-1:0] chrom_addr,
  input  logic [7:0]          chrom_q,
  output logic [7:0]          next_buf,
  output logic                busy
);

  fetch_state_t state;
  logic [2:0]   line_lo;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      chram_addr <= '0;
      chrom_addr <= '0;
      next_buf   <= '0;
      line_lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            chram_addr <= {1'b0, line[8:3], col};
            line_lo    <= line[2:0];
            state      <= ST_RAM_REQ;
          end
        end
        ST_RAM_REQ:  state <= ST_RAM_WAIT;
        ST_RAM_WAIT: begin
          chrom_addr <= {chram_q, line_lo};
          state      <= ST_ROM_REQ;
        end
        ST_ROM_REQ:  state <= ST_ROM_WAIT;
        ST_ROM_WAIT: begin
          next_buf <= chrom_q;
          state    <= ST_IDLE;
        end
        default:     state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/char_render.sv
// char_render
// Character-tile renderer: 40x30 tiles of 8x8 pixels (320x240 visible).
// Decodes fetch triggers from the timing counters, runs the glyph fetch and
// shifts glyph rows out as RGB.
//   clk_sys, reset_n : clock, async active-low reset
//   pxl_cen          : pixel clock enable
//   hcnt, vcnt       : timing counters
//   hblank, vblank   : blanking
//   mem              : char RAM / char ROM read ports
//   vid_r/g/b        : registered pixel colour
//   fetch_late       : sticky, a trigger arrived while a fetch was running
module char_render
  import char_render_pkg::*;
#(
  parameter logic [8:0]  H_PREFETCH = 9'd376,
  parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB     = 24'h000000
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                pxl_cen,
  input  logic [8:0]          hcnt,
  input  logic [8:0]          vcnt,
  input  logic                hblank,
  input  logic                vblank,
  char_render_if.master       mem,
  output logic [7:0]          vid_r,
  output logic [7:0]          vid_g,
  output logic [7:0]          vid_b,
  output logic                fetch_late
);

  logic       trig_col, trig_pre, trigger, busy;
  logic [5:0] fetch_col;
  logic [8:0] fetch_line;
  logic [7:0] next_buf, shreg, src;
  logic [23:0] rgb;

  // Column fetches run one tile ahead; the prefetch loads column 0 of the
  // next line during horizontal blank. H_PREFETCH >= 320 so they never overlap.
  assign trig_col   = pxl_cen && (hcnt[2:0] == 3'd0) && (hcnt < 9'd312);
  assign trig_pre   = pxl_cen && (hcnt == H_PREFETCH);
  assign trigger    = trig_col || trig_pre;
  assign fetch_col  = trig_pre ? 6'd0 : hcnt[8:3] + 6'd1;
  assign fetch_line = trig_pre ? vcnt + 9'd1 : vcnt;

  char_fetch_fsm u_fetch (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .trigger    (trigger),
    .col        (fetch_col),
    .line       (fetch_line),
    .chram_addr (mem.chram_addr),
    .chram_q    (mem.chram_q),
    .chrom_addr (mem.chrom_addr),
    .chrom_q    (mem.chrom_q),
    .next_buf   (next_buf),
    .busy       (busy)
  );

  // On a tile boundary the fresh glyph row replaces the shifter contents.
  assign src = (hcnt[2:0] == 3'd0) ? next_buf : shreg;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      rgb        <= '0;
      fetch_late <= 1'b0;
    end else begin
      if (trigger && busy)
        fetch_late <= 1'b1;
      if (pxl_cen) begin
        shreg <= {src[6:0], 1'b0};
        if (hblank || vblank)
          rgb <= '0;
        else
          rgb <= src[7] ? FG_RGB : BG_RGB;
      end
    end
  end

  assign vid_r = rgb[23:16];
  assign vid_g = rgb[15:8];
  assign vid_b = rgb[7:0];

endmodule
